// File: rtl/comp_pkg.sv
// ============================================================================
// comp_pkg : shared types and sizing helpers for the chunk-serial comparator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package comp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } comp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } comp_res_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index counter must be at least one bit wide even for a single chunk.
  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/comp_chunk.sv
// ============================================================================
// comp_chunk : combinational CHUNK-bit unsigned magnitude compare (gt/eq/lt).
// Revision   : 1.0
// ============================================================================
`default_nettype none

module comp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  assign gt_o = (a_i > b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i < b_i);

endmodule

`default_nettype wire

// File: rtl/comp_serial.sv
// ============================================================================
// comp_serial : chunk-serial N-bit magnitude comparator, MSB-first, early exit.
// Optional macro COMP_SIGNED_EN adds the sgn port for two's-complement compare.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module comp_serial
  import comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("comp_serial: WIDTH must be a non-zero multiple of CHUNK");
  end

  comp_state_t       state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  comp_res_t         res_q, res_d;
  logic              done_q, done_d;
  logic              flip;
  logic              c_gt, c_eq, c_lt;

`ifdef COMP_SIGNED_EN
  assign flip = sgn;
`else
  assign flip = 1'b0;
`endif

  comp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i  (a_sh_q[WIDTH-1 -: CHUNK]),
    .b_i  (b_sh_q[WIDTH-1 -: CHUNK]),
    .gt_o (c_gt),
    .eq_o (c_eq),
    .lt_o (c_lt)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    idx_d   = idx_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Inverting the sign bit maps two's-complement order onto unsigned order.
          a_sh_d  = a ^ (flip ? MSB_MASK : '0);
          b_sh_d  = b ^ (flip ? MSB_MASK : '0);
          idx_d   = CNT_W'(NCHUNK - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!c_eq) begin
          res_d   = '{gt: c_gt, eq: 1'b0, lt: c_lt};
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          res_d   = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          a_sh_d = a_sh_q << CHUNK;
          b_sh_d = b_sh_q << CHUNK;
          idx_d  = idx_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SCAN);
  assign done = done_q;
  assign gt   = res_q.gt;
  assign eq   = res_q.eq;
  assign lt   = res_q.lt;

endmodule

`default_nettype wire
